fixed_arith_core_seq: RTL and testbench

Parametrised, sequential successor to the 16-bit combinational fixed-point adder and multiplier. It operates on signed two's-complement Q(WIDTH-FRAC).FRAC operands and supports add, sub, mul and multiply-accumulate. Mul and MAC use an iterative shift-add engine. A valid/ready handshake sits on both the input and output sides, and results are registered with overflow and precision flags. It sits between the operand-entry logic and the display/result path of the Basys 3 design.

---
 rtl/fixed_arith_core_seq.sv | 111 +++++++++++
 tb/tb_fixed_arith_core_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_arith_core_seq.sv
// fixed_arith_core_seq: signed Q(WIDTH-FRAC).FRAC add/sub/mul/mac core with an iterative shift-add multiplier and valid/ready handshake
module fixed_arith_core_seq #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             precision_lost,
  output logic [WIDTH-1:0] acc
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] LIM = (2*WIDTH)'(1) << (WIDTH-1);
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  state_t             state;
  logic               mac_q, neg;
  logic [2*WIDTH-1:0] mcand, prod, scaled;
  logic [WIDTH-1:0]   mplier, abs1, abs2, sv, mul_res, acc_in, fin_res;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     as_sum, mac_sum;
  logic               accept, as_ovf, mul_ovf, mac_ovf, p_lost;
  // An exact (WIDTH+1)-bit sum overflows when its top two bits disagree; the top bit gives the true sign.
  function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] s);
    return (SATURATE != 0 && (s[WIDTH] ^ s[WIDTH-1])) ? (s[WIDTH] ? MINV : MAXV) : s[WIDTH-1:0];
  endfunction
  assign in_ready = (state == IDLE) && !out_valid;
  assign accept   = in_valid && in_ready;
  always_comb begin
    abs1    = num1[WIDTH-1] ? -num1 : num1;
    abs2    = num2[WIDTH-1] ? -num2 : num2;
    as_sum  = mode[0] ? {num1[WIDTH-1], num1} - {num2[WIDTH-1], num2}
                      : {num1[WIDTH-1], num1} + {num2[WIDTH-1], num2};
    as_ovf  = as_sum[WIDTH] ^ as_sum[WIDTH-1];
    scaled  = prod >> FRAC;
    p_lost  = |prod[FRAC-1:0];
    mul_ovf = scaled > (neg ? LIM : LIM - 1'b1);
    sv      = neg ? -scaled[WIDTH-1:0] : scaled[WIDTH-1:0];
    mul_res = (mul_ovf && SATURATE != 0) ? (neg ? MINV : MAXV) : sv;
    acc_in  = acc_clr ? '0 : acc;
    mac_sum = {mul_res[WIDTH-1], mul_res} + {acc_in[WIDTH-1], acc_in};
    mac_ovf = mac_sum[WIDTH] ^ mac_sum[WIDTH-1];
    fin_res = mac_q ? fit(mac_sum) : mul_res;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      result         <= '0;
      out_valid      <= 1'b0;
      overflow       <= 1'b0;
      precision_lost <= 1'b0;
      acc            <= '0;
      mac_q          <= 1'b0;
      neg            <= 1'b0;
      mcand          <= '0;
      mplier         <= '0;
      prod           <= '0;
      cnt            <= '0;
    end else begin
      if (acc_clr) acc <= '0;
      case (state)
        IDLE: if (accept) begin
          if (!mode[1]) begin
            result         <= fit(as_sum);
            overflow       <= as_ovf;
            precision_lost <= 1'b0;
            out_valid      <= 1'b1;
            state          <= OUT;
          end else begin
            mac_q  <= mode[0];
            neg    <= num1[WIDTH-1] ^ num2[WIDTH-1];
            mcand  <= {{WIDTH{1'b0}}, abs1};
            mplier <= abs2;
            prod   <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: if (cnt == CW'(WIDTH)) begin
          result         <= fin_res;
          overflow       <= mul_ovf | (mac_q & mac_ovf);
          precision_lost <= p_lost;
          out_valid      <= 1'b1;
          state          <= OUT;
          if (mac_q) acc <= fin_res;
        end else begin
          prod   <= prod + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_arith_core_seq.sv
// tb_fixed_arith_core_seq: directed bench for saturating and wrapping core instances against a transaction-level arithmetic model
module tb_fixed_arith_core_seq;
  localparam int W = 16;
  logic clk = 0, rst = 1, in_valid = 0, acc_clr = 0, out_ready = 0;
  logic [1:0] mode = 0;
  logic [15:0] num1 = 0, num2 = 0;
  logic in_ready[2], out_valid[2], overflow[2], precision_lost[2];
  logic [15:0] result[2], acc[2];
  int n_cmp = 0, n_err = 0, lat;
  logic [15:0] cap_res[2];
  logic cap_ovf[2], cap_pl[2];
  fixed_arith_core_seq #(.WIDTH(16), .FRAC(8), .SATURATE(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .mode(mode),
    .num1(num1), .num2(num2), .acc_clr(acc_clr), .result(result[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .overflow(overflow[0]), .precision_lost(precision_lost[0]), .acc(acc[0]));
  fixed_arith_core_seq #(.WIDTH(16), .FRAC(8), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .mode(mode),
    .num1(num1), .num2(num2), .acc_clr(acc_clr), .result(result[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .overflow(overflow[1]), .precision_lost(precision_lost[1]), .acc(acc[1]));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] fit(input longint v, input int sat, output logic o);
    o = v > 32767 || v < -32768;
    return (o && sat != 0) ? (v < 0 ? 16'h8000 : 16'h7FFF) : 16'(v);
  endfunction
  // Arithmetic on true signed values, then scaled, range-checked and clamped or wrapped.
  function automatic void model_op(input int sat, input logic [1:0] md, input logic [15:0] a, b, ai,
                                   output logic [15:0] r, output logic ovf, output logic pl);
    longint sa, sb, p, mag, sc;
    logic o2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pl = 1'b0;
    if (!md[1]) begin
      sc = md[0] ? sa - sb : sa + sb;
      r = fit(sc, sat, ovf);
    end else begin
      p = sa * sb;
      mag = p < 0 ? -p : p;
      pl = (mag % 256) != 0;
      sc = mag / 256;
      if (p < 0) sc = -sc;
      r = fit(sc, sat, ovf);
      if (md[0]) begin
        r = fit(longint'($signed(r)) + longint'($signed(ai)), sat, o2);
        ovf = ovf | o2;
      end
    end
  endfunction
  int m_pend;
  logic m_valid;
  logic [1:0] p_md;
  logic [15:0] p_a, p_b, m_res[2], m_acc[2], t_r;
  logic m_ovf[2], m_pl[2], t_o, t_p;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0;
      m_valid <= 0;
      for (int j = 0; j < 2; j++) begin
        m_res[j] <= 0; m_ovf[j] <= 0; m_pl[j] <= 0; m_acc[j] <= 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) if (acc_clr) m_acc[j] <= 0;
      if (m_valid) begin
        if (out_ready) m_valid <= 0;
      end else if (m_pend > 0) begin
        m_pend <= m_pend - 1;
        if (m_pend == 1) begin
          m_valid <= 1;
          for (int j = 0; j < 2; j++) begin
            model_op(j == 0 ? 1 : 0, p_md, p_a, p_b, acc_clr ? 16'h0 : m_acc[j], t_r, t_o, t_p);
            m_res[j] <= t_r; m_ovf[j] <= t_o; m_pl[j] <= t_p;
            if (p_md[0]) m_acc[j] <= t_r;
          end
        end
      end else if (in_valid) begin
        if (!mode[1]) begin
          m_valid <= 1;
          for (int j = 0; j < 2; j++) begin
            model_op(j == 0 ? 1 : 0, mode, num1, num2, 16'h0, t_r, t_o, t_p);
            m_res[j] <= t_r; m_ovf[j] <= t_o; m_pl[j] <= t_p;
          end
        end else begin
          m_pend <= W + 1;
          p_md <= mode; p_a <= num1; p_b <= num2;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("u%0d.out_valid", j), 32'(out_valid[j]), 32'(m_valid));
        chk($sformatf("u%0d.in_ready", j), 32'(in_ready[j]), 32'(!m_valid && m_pend == 0));
        chk($sformatf("u%0d.result", j), 32'(result[j]), 32'(m_res[j]));
        chk($sformatf("u%0d.overflow", j), 32'(overflow[j]), 32'(m_ovf[j]));
        chk($sformatf("u%0d.precision_lost", j), 32'(precision_lost[j]), 32'(m_pl[j]));
        chk($sformatf("u%0d.acc", j), 32'(acc[j]), 32'(m_acc[j]));
      end
    end
  end
  task automatic op(input logic [1:0] md, input logic [15:0] a, b, input int hold);
    mode = md; num1 = a; num2 = b; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; num1 = 16'hDEAD; num2 = 16'hBEEF; mode = ~md;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("result_timeout", 32'(lat < 40), 32'd1);
    for (int j = 0; j < 2; j++) begin
      cap_res[j] = result[j]; cap_ovf[j] = overflow[j]; cap_pl[j] = precision_lost[j];
    end
    if (hold > 0) begin
      in_valid = 1;
      repeat (hold) @(posedge clk);
      #1 in_valid = 0;
      chk("hold_result", 32'(result[0]), 32'(cap_res[0]));
      chk("hold_overflow", 32'(overflow[0]), 32'(cap_ovf[0]));
      chk("hold_out_valid", 32'(out_valid[0]), 32'd1);
      chk("hold_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", 32'(result[0]), 32'h0);
    chk("reset_out_valid", 32'(out_valid[0]), 32'h0);
    chk("reset_acc", 32'(acc[0]), 32'h0);
    rst = 0;
    @(posedge clk); #1;
    op(2'b00, 16'h001B, 16'h002A, 0);
    chk("add_res", 32'(cap_res[0]), 32'h0045);
    chk("add_ovf", 32'(cap_ovf[0]), 32'h0);
    chk("add_lat", 32'(lat), 32'd0);
    op(2'b10, 16'h0180, 16'h0240, 0);
    chk("mul_res", 32'(cap_res[0]), 32'h0360);
    chk("mul_lat", 32'(lat), 32'd17);
    chk("mul_pl", 32'(cap_pl[0]), 32'h0);
    op(2'b10, 16'hFE80, 16'h0200, 0);
    chk("mul_neg_res", 32'(cap_res[0]), 32'hFD00);
    op(2'b00, 16'h7000, 16'h2000, 0);
    chk("add_sat_res", 32'(cap_res[0]), 32'h7FFF);
    chk("add_sat_ovf", 32'(cap_ovf[0]), 32'h1);
    chk("add_wrap_res", 32'(cap_res[1]), 32'h9000);
    chk("add_wrap_ovf", 32'(cap_ovf[1]), 32'h1);
    op(2'b01, 16'h8000, 16'h0001, 0);
    chk("sub_sat_res", 32'(cap_res[0]), 32'h8000);
    chk("sub_sat_ovf", 32'(cap_ovf[0]), 32'h1);
    chk("sub_wrap_res", 32'(cap_res[1]), 32'h7FFF);
    op(2'b10, 16'h0001, 16'h0001, 0);
    chk("mul_tiny_res", 32'(cap_res[0]), 32'h0000);
    chk("mul_tiny_pl", 32'(cap_pl[0]), 32'h1);
    chk("mul_tiny_ovf", 32'(cap_ovf[0]), 32'h0);
    op(2'b10, 16'h8000, 16'h8000, 0);
    chk("mul_min_res", 32'(cap_res[0]), 32'h7FFF);
    chk("mul_min_ovf", 32'(cap_ovf[0]), 32'h1);
    chk("mul_min_wrap", 32'(cap_res[1]), 32'h0000);
    acc_clr = 1;
    @(posedge clk); #1;
    acc_clr = 0;
    op(2'b11, 16'h0100, 16'h0200, 5);
    chk("mac1_res", 32'(cap_res[0]), 32'h0200);
    op(2'b11, 16'h0100, 16'h0200, 0);
    chk("mac2_res", 32'(cap_res[0]), 32'h0400);
    chk("mac2_acc", 32'(acc[0]), 32'h0400);
    fork
      op(2'b11, 16'h0100, 16'h0100, 0);
      begin
        repeat (4) @(posedge clk);
        #1 acc_clr = 1;
        @(posedge clk);
        #1 acc_clr = 0;
      end
    join
    chk("mac_clr_res", 32'(cap_res[0]), 32'h0100);
    chk("mac_clr_acc", 32'(acc[0]), 32'h0100);
    mode = 2'b10; num1 = 16'h0180; num2 = 16'h0240; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("rst_result", 32'(result[j]), 32'h0);
      chk("rst_out_valid", 32'(out_valid[j]), 32'h0);
      chk("rst_flags", 32'({overflow[j], precision_lost[j]}), 32'h0);
      chk("rst_acc", 32'(acc[j]), 32'h0);
      chk("rst_in_ready", 32'(in_ready[j]), 32'h1);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    op(2'b00, 16'h0001, 16'h0001, 0);
    chk("post_rst_res", 32'(cap_res[0]), 32'h0002);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
